// File: rtl/debug_resp_lockstep_checker.sv
// Lockstep debug response checker: pairs left/right responses through a skew FIFO.
// Define LOCKSTEP_MISMATCH_CAPTURE_EN to latch the first mismatching pair.
module debug_resp_lockstep_checker #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     left_valid,
  input  logic [DATA_W-1:0]        left_data,
  input  logic                     right_valid,
  input  logic [DATA_W-1:0]        right_data,
  output logic                     mismatch,
  output logic                     overflow,
  output logic                     aligned,
  output logic [$clog2(DEPTH):0]   skew,
  output logic [15:0]              match_count,
  output logic [DATA_W-1:0]        mm_left_data,
  output logic [DATA_W-1:0]        mm_right_data
);

  localparam int PW = $clog2(DEPTH);
  localparam int SW = PW + 1;

  typedef enum logic [1:0] {
    EMPTY,
    LEFT_AHEAD,
    RIGHT_AHEAD
  } state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [SW-1:0]     cnt_q, cnt_d;
  logic              mismatch_q, mismatch_d;
  logic              overflow_q, overflow_d;
  logic [15:0]       match_q, match_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              push, pop, cmp_en, full;
  logic [DATA_W-1:0] push_data, cmp_l, cmp_r, head;

  assign head = mem_q[rd_ptr_q];
  assign full = (cnt_q == SW'(DEPTH));

  always_comb begin
    state_d   = state_q;
    push      = 1'b0;
    pop       = 1'b0;
    push_data = left_data;
    cmp_en    = 1'b0;
    cmp_l     = left_data;
    cmp_r     = right_data;
    overflow_d = overflow_q;
    unique case (state_q)
      EMPTY: begin
        if (left_valid && right_valid) begin
          cmp_en = 1'b1;
        end else if (left_valid) begin
          push    = 1'b1;
          state_d = LEFT_AHEAD;
        end else if (right_valid) begin
          push      = 1'b1;
          push_data = right_data;
          state_d   = RIGHT_AHEAD;
        end
      end
      LEFT_AHEAD: begin
        cmp_l = head;
        if (left_valid && right_valid) begin
          cmp_en = 1'b1;
          pop    = 1'b1;
          push   = 1'b1;
        end else if (left_valid) begin
          if (full) overflow_d = 1'b1;
          else      push       = 1'b1;
        end else if (right_valid) begin
          cmp_en = 1'b1;
          pop    = 1'b1;
          if (cnt_q == SW'(1)) state_d = EMPTY;
        end
      end
      RIGHT_AHEAD: begin
        cmp_r     = head;
        push_data = right_data;
        if (left_valid && right_valid) begin
          cmp_en = 1'b1;
          pop    = 1'b1;
          push   = 1'b1;
        end else if (right_valid) begin
          if (full) overflow_d = 1'b1;
          else      push       = 1'b1;
        end else if (left_valid) begin
          cmp_en = 1'b1;
          pop    = 1'b1;
          if (cnt_q == SW'(1)) state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    cnt_d      = cnt_q + SW'(push) - SW'(pop);
    mismatch_d = mismatch_q;
    match_d    = match_q;
    if (cmp_en) begin
      if (cmp_l != cmp_r)          mismatch_d = 1'b1;
      else if (match_q != 16'hFFFF) match_d   = match_q + 16'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= EMPTY;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      mismatch_q <= 1'b0;
      overflow_q <= 1'b0;
      match_q    <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      mismatch_q <= mismatch_d;
      overflow_q <= overflow_d;
      match_q    <= match_d;
    end
  end

  // Storage is left unreset; only pointers define validity.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

`ifdef LOCKSTEP_MISMATCH_CAPTURE_EN
  logic [DATA_W-1:0] mm_l_q, mm_l_d;
  logic [DATA_W-1:0] mm_r_q, mm_r_d;

  always_comb begin
    mm_l_d = mm_l_q;
    mm_r_d = mm_r_q;
    if (cmp_en && (cmp_l != cmp_r) && !mismatch_q) begin
      mm_l_d = cmp_l;
      mm_r_d = cmp_r;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mm_l_q <= '0;
      mm_r_q <= '0;
    end else begin
      mm_l_q <= mm_l_d;
      mm_r_q <= mm_r_d;
    end
  end

  assign mm_left_data  = mm_l_q;
  assign mm_right_data = mm_r_q;
`else
  assign mm_left_data  = '0;
  assign mm_right_data = '0;
`endif

  assign mismatch    = mismatch_q;
  assign overflow    = overflow_q;
  assign aligned     = (state_q == EMPTY);
  assign skew        = cnt_q;
  assign match_count = match_q;

endmodule

// File: tb/tb_debug_resp_lockstep_checker.sv
// Directed self-checking bench for debug_resp_lockstep_checker (DEPTH=4).
// Expected capture values follow LOCKSTEP_MISMATCH_CAPTURE_EN.
module tb_debug_resp_lockstep_checker;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        left_valid = 1'b0;
  logic [31:0] left_data = '0;
  logic        right_valid = 1'b0;
  logic [31:0] right_data = '0;
  logic        mismatch, overflow, aligned;
  logic [2:0]  skew;
  logic [15:0] match_count;
  logic [31:0] mm_left_data, mm_right_data;

  int n_cmp = 0;
  int n_fail = 0;

  debug_resp_lockstep_checker #(.DATA_W(32), .DEPTH(4)) dut (
    .clock(clock),
    .reset_n(reset_n),
    .left_valid(left_valid),
    .left_data(left_data),
    .right_valid(right_valid),
    .right_data(right_data),
    .mismatch(mismatch),
    .overflow(overflow),
    .aligned(aligned),
    .skew(skew),
    .match_count(match_count),
    .mm_left_data(mm_left_data),
    .mm_right_data(mm_right_data)
  );

  always #5 clock = ~clock;

  task automatic step(input logic lv, input logic [31:0] ld,
                      input logic rv, input logic [31:0] rd);
    left_valid  = lv;
    left_data   = ld;
    right_valid = rv;
    right_data  = rd;
    @(posedge clock);
    #1;
    left_valid  = 1'b0;
    right_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (skew !== 3'd0) begin n_fail++; $display("FAIL rst_skew got %0d want 0", skew); end
    n_cmp++; if (aligned !== 1'b1) begin n_fail++; $display("FAIL rst_aligned got %b want 1", aligned); end
    n_cmp++; if (mismatch !== 1'b0) begin n_fail++; $display("FAIL rst_mismatch got %b want 0", mismatch); end
    n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rst_overflow got %b want 0", overflow); end
    n_cmp++; if (match_count !== 16'd0) begin n_fail++; $display("FAIL rst_match got %0d want 0", match_count); end
    n_cmp++; if (mm_left_data !== 32'd0 || mm_right_data !== 32'd0) begin
      n_fail++; $display("FAIL rst_mm got %h/%h want 0/0", mm_left_data, mm_right_data);
    end
  endtask

  task automatic test_same_cycle();
    do_reset();
    step(1'b1, 32'h11, 1'b1, 32'h11);
    n_cmp++; if (match_count !== 16'd1) begin n_fail++; $display("FAIL same_match got %0d want 1", match_count); end
    n_cmp++; if (aligned !== 1'b1) begin n_fail++; $display("FAIL same_aligned got %b want 1", aligned); end
    n_cmp++; if (mismatch !== 1'b0) begin n_fail++; $display("FAIL same_mismatch got %b want 0", mismatch); end
  endtask

  task automatic test_skew();
    do_reset();
    step(1'b1, 32'hA, 1'b0, 32'h0);
    n_cmp++; if (skew !== 3'd1) begin n_fail++; $display("FAIL skew_c0 got %0d want 1", skew); end
    step(1'b1, 32'hB, 1'b0, 32'h0);
    n_cmp++; if (skew !== 3'd2) begin n_fail++; $display("FAIL skew_c1 got %0d want 2", skew); end
    n_cmp++; if (aligned !== 1'b0) begin n_fail++; $display("FAIL skew_aligned got %b want 0", aligned); end
    step(1'b0, 32'h0, 1'b0, 32'h0);
    step(1'b0, 32'h0, 1'b1, 32'hA);
    n_cmp++; if (skew !== 3'd1) begin n_fail++; $display("FAIL skew_c3 got %0d want 1", skew); end
    step(1'b0, 32'h0, 1'b1, 32'hB);
    n_cmp++; if (skew !== 3'd0) begin n_fail++; $display("FAIL skew_c4 got %0d want 0", skew); end
    n_cmp++; if (match_count !== 16'd2) begin n_fail++; $display("FAIL skew_match got %0d want 2", match_count); end
    n_cmp++; if (mismatch !== 1'b0) begin n_fail++; $display("FAIL skew_mismatch got %b want 0", mismatch); end
    n_cmp++; if (aligned !== 1'b1) begin n_fail++; $display("FAIL skew_realign got %b want 1", aligned); end
  endtask

  task automatic test_mismatch();
    logic [31:0] exp_l, exp_r;
`ifdef LOCKSTEP_MISMATCH_CAPTURE_EN
    exp_l = 32'h6;
    exp_r = 32'h5;
`else
    exp_l = 32'h0;
    exp_r = 32'h0;
`endif
    do_reset();
    step(1'b0, 32'h0, 1'b1, 32'h5);
    n_cmp++; if (mismatch !== 1'b0) begin n_fail++; $display("FAIL mm_early got %b want 0", mismatch); end
    step(1'b1, 32'h6, 1'b0, 32'h0);
    n_cmp++; if (mismatch !== 1'b1) begin n_fail++; $display("FAIL mm_flag got %b want 1", mismatch); end
    n_cmp++; if (mm_left_data !== exp_l) begin n_fail++; $display("FAIL mm_left got %h want %h", mm_left_data, exp_l); end
    n_cmp++; if (mm_right_data !== exp_r) begin n_fail++; $display("FAIL mm_right got %h want %h", mm_right_data, exp_r); end
    step(1'b1, 32'h8, 1'b1, 32'h7);
    step(1'b1, 32'h9, 1'b1, 32'h9);
    n_cmp++; if (mm_left_data !== exp_l || mm_right_data !== exp_r) begin
      n_fail++; $display("FAIL mm_keep got %h/%h want %h/%h", mm_left_data, mm_right_data, exp_l, exp_r);
    end
    n_cmp++; if (mismatch !== 1'b1) begin n_fail++; $display("FAIL mm_sticky got %b want 1", mismatch); end
    n_cmp++; if (match_count !== 16'd1) begin n_fail++; $display("FAIL mm_count got %0d want 1", match_count); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 1; i <= 4; i++) step(1'b1, 32'(i), 1'b0, 32'h0);
    n_cmp++; if (skew !== 3'd4 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL ovf_full got skew %0d ovf %b want 4 0", skew, overflow);
    end
    step(1'b1, 32'h5, 1'b0, 32'h0);
    n_cmp++; if (skew !== 3'd4 || overflow !== 1'b1) begin
      n_fail++; $display("FAIL ovf_set got skew %0d ovf %b want 4 1", skew, overflow);
    end
    for (int i = 1; i <= 4; i++) step(1'b1, 32'(i + 9), 1'b1, 32'(i));
    n_cmp++; if (skew !== 3'd4 || overflow !== 1'b1) begin
      n_fail++; $display("FAIL ovf_both got skew %0d ovf %b want 4 1", skew, overflow);
    end
    n_cmp++; if (match_count !== 16'd4 || mismatch !== 1'b0) begin
      n_fail++; $display("FAIL ovf_pairs got %0d mm %b want 4 0", match_count, mismatch);
    end
    for (int i = 1; i <= 4; i++) step(1'b0, 32'h0, 1'b1, 32'(i + 9));
    n_cmp++; if (skew !== 3'd0 || aligned !== 1'b1) begin
      n_fail++; $display("FAIL ovf_drain got skew %0d al %b want 0 1", skew, aligned);
    end
    n_cmp++; if (match_count !== 16'd8 || mismatch !== 1'b0) begin
      n_fail++; $display("FAIL ovf_wrap got %0d mm %b want 8 0", match_count, mismatch);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    step(1'b1, 32'h1, 1'b1, 32'h2);
    for (int i = 0; i < 3; i++) step(1'b1, 32'(i + 40), 1'b0, 32'h0);
    n_cmp++; if (skew !== 3'd3 || mismatch !== 1'b1) begin
      n_fail++; $display("FAIL mid_pre got skew %0d mm %b want 3 1", skew, mismatch);
    end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++; if (skew !== 3'd0 || aligned !== 1'b1) begin
      n_fail++; $display("FAIL mid_async got skew %0d al %b want 0 1", skew, aligned);
    end
    n_cmp++; if (mismatch !== 1'b0 || overflow !== 1'b0 || match_count !== 16'd0) begin
      n_fail++; $display("FAIL mid_flags got mm %b ovf %b cnt %0d want 0 0 0", mismatch, overflow, match_count);
    end
    @(posedge clock);
    #1 reset_n = 1'b1;
    step(1'b1, 32'h22, 1'b1, 32'h22);
    n_cmp++; if (match_count !== 16'd1 || aligned !== 1'b1 || skew !== 3'd0) begin
      n_fail++; $display("FAIL mid_after got cnt %0d al %b skew %0d want 1 1 0", match_count, aligned, skew);
    end
  endtask

  initial begin
    test_reset();
    test_same_cycle();
    test_skew();
    test_mismatch();
    test_overflow();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/debug_resp_lockstep_checker.md
DEBUG_RESP_LOCKSTEP_CHECKER -- requirements
Module: debug_resp_lockstep_checker

Interface
REQ-001 SHALL have parameter DATA_W, default 32, the debug response data width.
REQ-002 SHALL have parameter DEPTH, default 4, the skew buffer entries; power of two, 2..16.
REQ-003 SHALL have port clock, input, 1: the single clock; all state samples on its rising edge.
REQ-004 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port left_valid, input, 1: left-copy debug response valid.
REQ-006 SHALL have port left_data, input, DATA_W: left-copy debug response data.
REQ-007 SHALL have port right_valid, input, 1: right-copy debug response valid.
REQ-008 SHALL have port right_data, input, DATA_W: right-copy debug response data.
REQ-009 SHALL have port mismatch, output, 1: sticky; a paired response differed.
REQ-010 SHALL have port overflow, output, 1: sticky; skew exceeded DEPTH.
REQ-011 SHALL have port aligned, output, 1: high when the state is EMPTY.
REQ-012 SHALL have port skew, output, clog2(DEPTH)+1: number of buffered unpaired responses.
REQ-013 SHALL have port match_count, output, 16: number of equal pairs, saturating.
REQ-014 SHALL have port mm_left_data, output, DATA_W: left value of the first mismatching pair.
REQ-015 SHALL have port mm_right_data, output, DATA_W: right value of the first mismatching pair.

Function
REQ-016 SHALL pair the Nth left response with the Nth right response, in order, regardless of arrival cycle.
REQ-017 SHALL implement a FIFO of DEPTH entries holding responses from the leading side only, with states EMPTY, LEFT_AHEAD and RIGHT_AHEAD.
REQ-018 In EMPTY with both valids high, SHALL compare left_data against right_data directly, with no push; the state stays EMPTY.
REQ-019 In EMPTY with one valid high, SHALL push that side's data and move to that side's AHEAD state.
REQ-020 In an AHEAD state, a response from the leading side alone SHALL push; if skew==DEPTH it SHALL instead drop the data and set overflow.
REQ-021 In an AHEAD state, a response from the lagging side alone SHALL compare it against the FIFO head and pop; at skew 1 the state SHALL return to EMPTY.
REQ-022 In an AHEAD state with both valids high, SHALL compare the lagging data against the head, pop, and push the leading data in the same cycle; skew is unchanged, and this holds even when the FIFO is full (no overflow).
REQ-023 Each comparison SHALL update outputs one cycle later:
- equal: increment match_count, saturating at 16'hFFFF;
- unequal: set mismatch.
REQ-024 FIFO pointers SHALL wrap modulo DEPTH; skew SHALL never exceed DEPTH.
REQ-025 After mismatch or overflow is set, the block SHALL keep pairing and counting; the flags SHALL stay set until reset.

Reset
REQ-026 Assertion of reset_n low SHALL immediately give:
- state EMPTY, skew 0, aligned 1;
- mismatch 0, overflow 0, match_count 0;
- mm_left_data 0, mm_right_data 0.
REQ-027 Reset mid-operation SHALL discard all buffered entries; responses presented in the first cycle after deassertion SHALL be processed normally.
REQ-028 FIFO storage contents need no reset; only pointers and state do.

Configuration
REQ-029 With LOCKSTEP_MISMATCH_CAPTURE_EN defined:
- the first unequal comparison SHALL latch both compared values into mm_left_data and mm_right_data, one cycle after the comparison;
- later mismatches SHALL not overwrite them.
REQ-030 Without LOCKSTEP_MISMATCH_CAPTURE_EN, mm_left_data and mm_right_data SHALL be constant 0 and no capture registers SHALL be built.

Verification
REQ-031 Left and right both present 32'h11 in the same cycle -> next cycle match_count=1, aligned=1, mismatch=0.
REQ-032 Left presents 32'hA, 32'hB in cycles 0 and 1; right presents the same values in cycles 3 and 4 -> skew rises to 2 then falls to 0; match_count=2, mismatch=0.
REQ-033 Right leads with 32'h5 and left later presents 32'h6 -> mismatch=1; with the macro, mm_left_data=32'h6 and mm_right_data=32'h5; without it, both are 0.
REQ-034 With DEPTH=4, left sends 5 responses and right sends none -> skew=4, overflow=1; then with both sides valid every cycle, skew stays 4 and overflow stays set.
REQ-035 Left pushes 3 entries, then reset_n is pulsed low mid-stream -> skew=0, aligned=1, all flags 0, and the next same-cycle equal pair gives match_count=1.
